// File: rtl/mem_refill_responder.sv
// mem_refill_responder: main-memory side of the cache line-refill interface.
// Accepts a one-cycle refill request, waits FIRST_LATENCY cycles, then returns
// the whole line one word per ack pulse, critical word first, wrapping through
// the line. BEAT_GAP idle cycles may separate consecutive beats.
// The word-addressed backing store is loaded through a backdoor write port.
// Optional build macro MEM_RESP_STALL_EN adds input stall_mem2cc, which freezes
// the latency/gap counters and defers any due beat while high.
module mem_refill_responder #(
  parameter int unsigned WORD_WIDTH        = 32,
  parameter int unsigned ADR_WIDTH         = 32,
  parameter int unsigned MEM_ADR_WIDTH     = 12,
  parameter int unsigned WORD_OFFSET_WIDTH = 2,
  parameter int unsigned WORD_NUM          = 4,
  parameter int unsigned FIRST_LATENCY     = 4,
  parameter int unsigned BEAT_GAP          = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_cc2mem,
  input  logic [ADR_WIDTH-1:0]     adr_cc2mem,
`ifdef MEM_RESP_STALL_EN
  input  logic                     stall_mem2cc,
`endif
  output logic                     ack_mem2cc,
  output logic [WORD_WIDTH-1:0]    dat_mem2cc,
  output logic                     busy_mem,
  output logic                     overlap_err,
  input  logic                     we_ld2mem,
  input  logic [MEM_ADR_WIDTH-1:0] adr_ld2mem,
  input  logic [WORD_WIDTH-1:0]    dat_ld2mem
);

  localparam int unsigned LINE_W = ADR_WIDTH - 2 - WORD_OFFSET_WIDTH;
  localparam int unsigned BEAT_W = WORD_OFFSET_WIDTH + 1;
  localparam int unsigned LAT_W  = (FIRST_LATENCY > 1) ? $clog2(FIRST_LATENCY + 1) : 1;
  localparam int unsigned GAP_W  = (BEAT_GAP > 0) ? $clog2(BEAT_GAP + 1) : 1;
  localparam int unsigned DEPTH  = 1 << MEM_ADR_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    LATENCY,
    BURST,
    GAP
  } state_t;

  state_t                       state_q, state_d;
  logic [LINE_W-1:0]            line_q, line_d;
  logic [WORD_OFFSET_WIDTH-1:0] crit_q, crit_d;
  logic [BEAT_W-1:0]            beat_q, beat_d;
  logic [LAT_W-1:0]             lat_q, lat_d;
  logic [GAP_W-1:0]             gap_q, gap_d;
  logic                         ack_q, ack_d;
  logic [WORD_WIDTH-1:0]        dat_q, dat_d;
  logic                         busy_q, busy_d;
  logic                         ovl_q, ovl_d;

  logic [WORD_WIDTH-1:0]        mem_q [DEPTH];

  logic                         stall;
  logic                         emit;
  logic [LINE_W-1:0]            req_line;
  logic [WORD_OFFSET_WIDTH-1:0] req_crit;
  logic [LINE_W-1:0]            rd_line;
  logic [WORD_OFFSET_WIDTH-1:0] rd_off;
  logic [LINE_W+WORD_OFFSET_WIDTH-1:0] rd_word;
  logic [MEM_ADR_WIDTH-1:0]     rd_idx;
  logic [WORD_WIDTH-1:0]        rd_data;
  logic                         unused_ok;

`ifdef MEM_RESP_STALL_EN
  assign stall = stall_mem2cc;
`else
  assign stall = 1'b0;
`endif

  assign req_line = adr_cc2mem[ADR_WIDTH-1 -: LINE_W];
  assign req_crit = adr_cc2mem[2 +: WORD_OFFSET_WIDTH];

  // Byte-offset bits and the aliased high word-index bits are intentionally dropped.
  assign unused_ok = ^{adr_cc2mem[1:0], rd_word};

  // Select the store word for the beat that may issue at this edge. In IDLE the
  // only possible beat is the critical word of a FIRST_LATENCY=1 request, so the
  // index comes straight from the request; otherwise from the latched line.
  always_comb begin
    rd_line = line_q;
    rd_off  = crit_q + beat_q[WORD_OFFSET_WIDTH-1:0];
    if (state_q == IDLE) begin
      rd_line = req_line;
      rd_off  = req_crit;
    end
    rd_word = {rd_line, rd_off};
    rd_idx  = rd_word[MEM_ADR_WIDTH-1:0];
    rd_data = mem_q[rd_idx];
  end

  // Backing store: backdoor write only, no reset; beat reads see pre-edge data.
  always_ff @(posedge clk) begin
    if (we_ld2mem) begin
      mem_q[adr_ld2mem] <= dat_ld2mem;
    end
  end

  // Next-state, beat sequencing and registered-output computation.
  // State BURST marks the cycle in which ack is high; a beat "emits" at the edge
  // that enters BURST, so the last-beat cycle is still busy and non-IDLE.
  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    crit_d  = crit_q;
    beat_d  = beat_q;
    lat_d   = lat_q;
    gap_d   = gap_q;
    ack_d   = 1'b0;
    dat_d   = dat_q;
    ovl_d   = ovl_q;
    emit    = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_cc2mem) begin
          line_d = req_line;
          crit_d = req_crit;
          beat_d = '0;
          if (FIRST_LATENCY <= 1 && !stall) begin
            emit = 1'b1;
          end else begin
            state_d = LATENCY;
            lat_d   = (FIRST_LATENCY <= 1) ? LAT_W'(1) : LAT_W'(FIRST_LATENCY - 1);
          end
        end
      end
      LATENCY: begin
        if (!stall) begin
          if (lat_q <= LAT_W'(1)) begin
            emit = 1'b1;
          end else begin
            lat_d = lat_q - LAT_W'(1);
          end
        end
      end
      BURST: begin
        if (beat_q == BEAT_W'(WORD_NUM)) begin
          state_d = IDLE;
          beat_d  = '0;
        end else if (BEAT_GAP == 0 && !stall) begin
          emit = 1'b1;
        end else begin
          // A stalled back-to-back beat parks in GAP with a zero count.
          state_d = GAP;
          gap_d   = GAP_W'(BEAT_GAP);
        end
      end
      GAP: begin
        if (!stall) begin
          if (gap_q <= GAP_W'(1)) begin
            emit = 1'b1;
          end else begin
            gap_d = gap_q - GAP_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (req_cc2mem && state_q != IDLE) begin
      ovl_d = 1'b1;
    end

    // beat_q is zero whenever IDLE, so the increment is valid from every state.
    if (emit) begin
      state_d = BURST;
      ack_d   = 1'b1;
      dat_d   = rd_data;
      beat_d  = beat_q + BEAT_W'(1);
    end

    busy_d = (state_d != IDLE);
  end

  // Control and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      line_q  <= '0;
      crit_q  <= '0;
      beat_q  <= '0;
      lat_q   <= '0;
      gap_q   <= '0;
      ack_q   <= 1'b0;
      dat_q   <= '0;
      busy_q  <= 1'b0;
      ovl_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      crit_q  <= crit_d;
      beat_q  <= beat_d;
      lat_q   <= lat_d;
      gap_q   <= gap_d;
      ack_q   <= ack_d;
      dat_q   <= dat_d;
      busy_q  <= busy_d;
      ovl_q   <= ovl_d;
    end
  end

  assign ack_mem2cc  = ack_q;
  assign dat_mem2cc  = dat_q;
  assign busy_mem    = busy_q;
  assign overlap_err = ovl_q;

endmodule

// File: tb/tb_mem_refill_responder.sv
// Testbench for mem_refill_responder: two instances (latency 4 / no gap, and
// latency 1 / gap 2) sharing clock, reset and the backdoor port. Expected beats
// (data and observation cycle) are queued at request time; per-instance
// monitors pop and compare on every ack.
module tb_mem_refill_responder;

  typedef struct {
    logic [31:0] dat;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_a, req_b;
  logic [31:0] adr_a, adr_b;
  logic        ack_a, ack_b;
  logic [31:0] dat_a, dat_b;
  logic        busy_a, busy_b;
  logic        ovl_a, ovl_b;
  logic        we;
  logic [11:0] wadr;
  logic [31:0] wdat;
`ifdef MEM_RESP_STALL_EN
  logic        stall_a;
`endif

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_refill_responder u_dut_a (
    .clk         (clk),
    .rst         (rst),
    .req_cc2mem  (req_a),
    .adr_cc2mem  (adr_a),
`ifdef MEM_RESP_STALL_EN
    .stall_mem2cc(stall_a),
`endif
    .ack_mem2cc  (ack_a),
    .dat_mem2cc  (dat_a),
    .busy_mem    (busy_a),
    .overlap_err (ovl_a),
    .we_ld2mem   (we),
    .adr_ld2mem  (wadr),
    .dat_ld2mem  (wdat)
  );

  mem_refill_responder #(
    .FIRST_LATENCY(1),
    .BEAT_GAP     (2)
  ) u_dut_b (
    .clk         (clk),
    .rst         (rst),
    .req_cc2mem  (req_b),
    .adr_cc2mem  (adr_b),
`ifdef MEM_RESP_STALL_EN
    .stall_mem2cc(1'b0),
`endif
    .ack_mem2cc  (ack_b),
    .dat_mem2cc  (dat_b),
    .busy_mem    (busy_b),
    .overlap_err (ovl_b),
    .we_ld2mem   (we),
    .adr_ld2mem  (wadr),
    .dat_ld2mem  (wdat)
  );

  always @(negedge clk) begin
    if (ack_a === 1'b1) begin
      checks++;
      if (qa.size() == 0) begin
        errors++;
        $display("FAIL beat_a_extra: dat=%h at cyc %0d, required no beat", dat_a, cyc);
      end else begin
        ea = qa.pop_front();
        if (dat_a !== ea.dat || cyc != ea.cyc) begin
          errors++;
          $display("FAIL beat_a: dat=%h cyc=%0d, required dat=%h cyc=%0d", dat_a, cyc, ea.dat, ea.cyc);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (ack_b === 1'b1) begin
      checks++;
      if (qb.size() == 0) begin
        errors++;
        $display("FAIL beat_b_extra: dat=%h at cyc %0d, required no beat", dat_b, cyc);
      end else begin
        eb = qb.pop_front();
        if (dat_b !== eb.dat || cyc != eb.cyc) begin
          errors++;
          $display("FAIL beat_b: dat=%h cyc=%0d, required dat=%h cyc=%0d", dat_b, cyc, eb.dat, eb.cyc);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic push_line(input bit to_b, input int first, input int step,
                           input logic [31:0] d0, input logic [31:0] d1,
                           input logic [31:0] d2, input logic [31:0] d3);
    logic [31:0] d [4];
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    for (int i = 0; i < 4; i++) begin
      exp_t e;
      e.dat = d[i];
      e.cyc = first + i * step;
      if (to_b) qb.push_back(e);
      else      qa.push_back(e);
    end
  endtask

  task automatic wait_to(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic bd_write(input logic [11:0] a, input logic [31:0] d);
    we = 1'b1; wadr = a; wdat = d;
    @(negedge clk);
    we = 1'b0;
  endtask

  initial begin
    int c;
    rst = 1'b1;
    req_a = 1'b0; req_b = 1'b0;
    adr_a = '0;   adr_b = '0;
    we = 1'b0; wadr = '0; wdat = '0;
`ifdef MEM_RESP_STALL_EN
    stall_a = 1'b0;
`endif
    @(negedge clk);
    @(negedge clk);
    chk("rst_ack_a",  {31'b0, ack_a},  32'd0);
    chk("rst_dat_a",  dat_a,           32'd0);
    chk("rst_busy_a", {31'b0, busy_a}, 32'd0);
    chk("rst_ovl_a",  {31'b0, ovl_a},  32'd0);
    chk("rst_ack_b",  {31'b0, ack_b},  32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 4; i++) bd_write(12'(64 + i), 32'(160 + i));
    @(negedge clk);

    // crit 0, latency 4, back-to-back
    c = cyc; req_a = 1'b1; adr_a = 32'h100;
    push_line(1'b0, c + 4, 1, 32'hA0, 32'hA1, 32'hA2, 32'hA3);
    @(negedge clk); req_a = 1'b0; adr_a = 32'hFFFF_FFFF;
    wait_to(c + 7); chk("busy_last_beat_a", {31'b0, busy_a}, 32'd1);
    wait_to(c + 8); chk("busy_drop_a", {31'b0, busy_a}, 32'd0);
    @(negedge clk);

    // crit 2 wraps through the line
    c = cyc; req_a = 1'b1; adr_a = 32'h10A;
    push_line(1'b0, c + 4, 1, 32'hA2, 32'hA3, 32'hA0, 32'hA1);
    @(negedge clk); req_a = 1'b0;
    wait_to(c + 9);

    // latency 1, gap 2, crit 3
    c = cyc; req_b = 1'b1; adr_b = 32'h10C;
    push_line(1'b1, c + 1, 3, 32'hA3, 32'hA0, 32'hA1, 32'hA2);
    @(negedge clk); req_b = 1'b0;
    wait_to(c + 10); chk("busy_last_beat_b", {31'b0, busy_b}, 32'd1);
    wait_to(c + 11); chk("busy_drop_b", {31'b0, busy_b}, 32'd0);
    @(negedge clk);

    // overlapping request is ignored and flagged
    c = cyc; req_a = 1'b1; adr_a = 32'h100;
    push_line(1'b0, c + 4, 1, 32'hA0, 32'hA1, 32'hA2, 32'hA3);
    @(negedge clk); req_a = 1'b0;
    @(negedge clk); req_a = 1'b1; adr_a = 32'h10C;
    @(negedge clk); req_a = 1'b0;
    wait_to(c + 4);
    chk("overlap_a", {31'b0, ovl_a}, 32'd1);
    chk("overlap_b_clear", {31'b0, ovl_b}, 32'd0);
    wait_to(c + 10);

    // backdoor writes during a burst: earlier write visible, same-edge write not
    c = cyc; req_a = 1'b1; adr_a = 32'h100;
    push_line(1'b0, c + 4, 1, 32'hA0, 32'hA1, 32'hA2, 32'h88);
    @(negedge clk); req_a = 1'b0;
    wait_to(c + 4); we = 1'b1; wadr = 12'h043; wdat = 32'h88;
    @(negedge clk); wadr = 12'h042; wdat = 32'h77;
    @(negedge clk); we = 1'b0;
    wait_to(c + 9);
    bd_write(12'h042, 32'hA2);
    bd_write(12'h043, 32'hA3);
    @(negedge clk);

    // reset during beat 2
    chk("overlap_sticky_a", {31'b0, ovl_a}, 32'd1);
    c = cyc; req_a = 1'b1; adr_a = 32'h100;
    push_line(1'b0, c + 4, 1, 32'hA0, 32'hA1, 32'hA2, 32'hA3);
    void'(qa.pop_back());
    void'(qa.pop_back());
    @(negedge clk); req_a = 1'b0;
    wait_to(c + 5);
    @(posedge clk); #1;
    chk("beat2_started_a", {31'b0, ack_a}, 32'd1);
    rst = 1'b1; #1;
    chk("rst_mid_ack_a",  {31'b0, ack_a},  32'd0);
    chk("rst_mid_busy_a", {31'b0, busy_a}, 32'd0);
    chk("rst_mid_ovl_a",  {31'b0, ovl_a},  32'd0);
    @(negedge clk); rst = 1'b0;
    repeat (8) @(negedge clk);
    c = cyc; req_a = 1'b1; adr_a = 32'h104;
    push_line(1'b0, c + 4, 1, 32'hA1, 32'hA2, 32'hA3, 32'hA0);
    @(negedge clk); req_a = 1'b0;
    wait_to(c + 9);

`ifdef MEM_RESP_STALL_EN
    // stall over the first beat's due cycle delays the line by 3 cycles
    c = cyc; req_a = 1'b1; adr_a = 32'h10A;
    push_line(1'b0, c + 7, 1, 32'hA2, 32'hA3, 32'hA0, 32'hA1);
    @(negedge clk); req_a = 1'b0;
    wait_to(c + 3); stall_a = 1'b1;
    wait_to(c + 5); chk("stall_busy_a", {31'b0, busy_a}, 32'd1);
    wait_to(c + 6); stall_a = 1'b0;
    wait_to(c + 12);
`endif

    repeat (4) @(negedge clk);
    chk("pending_beats_a", 32'(qa.size()), 32'd0);
    chk("pending_beats_b", 32'(qb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_refill_responder.md
Name: mem_refill_responder

Overview:
- Main-memory responder for the cache line-refill interface; the memory-side counterpart of the 4-way cache controller's miss path.
- Accepts a single-cycle refill request carrying the missed word address.
- After a fixed latency, returns the whole line one word per ack pulse, critical word first, wrapping through the line.
- Holds a word-addressed backing store; the bench preloads it through a backdoor write port.

Parameters:
- WORD_WIDTH, 32, data word width.
- ADR_WIDTH, 32, byte address width.
- MEM_ADR_WIDTH, 12, backing-store word-index width; depth is 2**MEM_ADR_WIDTH words.
- WORD_OFFSET_WIDTH, 2, word-in-line index width.
- WORD_NUM, 4, words per line; must equal 2**WORD_OFFSET_WIDTH.
- FIRST_LATENCY, 4, cycles from the req sample edge to the first ack cycle; minimum 1.
- BEAT_GAP, 0, idle cycles between consecutive acks; 0 means back-to-back.

Ports:
- clk, in, 1, clock.
- rst, in, 1, asynchronous active-high reset.
- req_cc2mem, in, 1, refill request; single-cycle pulse.
- adr_cc2mem, in, ADR_WIDTH, missed byte address; valid with req_cc2mem.
- ack_mem2cc, out, 1, one-cycle beat strobe.
- dat_mem2cc, out, WORD_WIDTH, beat data; valid while ack_mem2cc is high.
- busy_mem, out, 1, high from request acceptance through the last beat.
- overlap_err, out, 1, sticky; set when req_cc2mem arrives while busy.
- we_ld2mem, in, 1, backdoor store write enable.
- adr_ld2mem, in, MEM_ADR_WIDTH, backdoor word index.
- dat_ld2mem, in, WORD_WIDTH, backdoor write data.

Behaviour:
- Reset: asynchronous, active-high. ack_mem2cc=0, dat_mem2cc=0, busy_mem=0, overlap_err=0, state=IDLE, counters=0. Backing-store contents are not reset.
- Address split: word index = adr[ADR_WIDTH-1:2]. line base = adr[ADR_WIDTH-1:2+WORD_OFFSET_WIDTH]. crit = adr[3:2]. Store index = low MEM_ADR_WIDTH bits of {line base, offset}; higher address bits alias.
- IDLE: when req_cc2mem=1 at edge N, latch line base and crit, set beat=0, busy_mem=1, go to LATENCY with lat_cnt=FIRST_LATENCY-1.
- LATENCY: decrement lat_cnt each cycle. Sequence the machine so the first ack is high in the cycle following edge N+FIRST_LATENCY-1; with FIRST_LATENCY=1, ack is high in the cycle right after the request cycle.
- BURST: ack_mem2cc=1 for exactly one cycle. dat_mem2cc = store[{line, (crit+beat) mod WORD_NUM}]. Offset arithmetic is WORD_OFFSET_WIDTH bits and wraps naturally.
  - After the beat: beat+1.
  - If beat was WORD_NUM-1: go to IDLE, busy_mem=0 next cycle.
  - Else if BEAT_GAP>0: go to GAP for BEAT_GAP cycles.
  - Else: stay in BURST.
- GAP: ack_mem2cc=0, dat_mem2cc holds its last value; after BEAT_GAP cycles return to BURST.
- Outputs: ack_mem2cc and dat_mem2cc are registered; no combinational path from any input.
- Request rules:
  - Requests are accepted only in IDLE.
  - req_cc2mem in any other state, including the last-beat cycle, is ignored and sets overlap_err (cleared only by rst).
  - adr_cc2mem is sampled only at acceptance; later changes have no effect.
- Backdoor port: we_ld2mem writes store[adr_ld2mem] at the clock edge; accepted in every state.
  - Same-edge write and beat read of the same index: the beat returns the old data (read-before-write).
  - A write to a not-yet-returned word of the active line is visible to that later beat.
- Reset mid-burst: ack drops immediately, state returns to IDLE, the remaining beats are discarded, and no beat is emitted after rst releases.

Optional Feature:
- Macro: MEM_RESP_STALL_EN.
- Defined: adds input stall_mem2cc (1 bit).
  - While stall_mem2cc=1, the LATENCY and GAP counters freeze and any beat due is deferred; ack_mem2cc stays 0.
  - The beat issues in the first cycle after the stall releases.
  - Beat order and data are unchanged. busy_mem stays high throughout.
- Undefined: no port; timing exactly as above.

Test Plan:
- Preload store[0x40..0x43]=0xA0..0xA3; req with adr=0x100 (crit 0), FIRST_LATENCY=4, BEAT_GAP=0 -> acks on 4 consecutive cycles starting at req edge+4, data 0xA0,0xA1,0xA2,0xA3; busy_mem then drops.
- Same preload; adr=0x10A (crit 2) -> data order 0xA2,0xA3,0xA0,0xA1.
- BEAT_GAP=2, adr=0x10C -> data 0xA3,0xA0,0xA1,0xA2 with exactly 2 idle cycles between acks; 4 acks total.
- Second req pulse 2 cycles after the first -> overlap_err=1, still exactly 4 beats of the first line, no extra beats.
- Assert rst during beat 2 -> ack_mem2cc=0 within the same cycle; no further acks; a new req after release returns a full 4-beat line.
- MEM_RESP_STALL_EN defined: stall_mem2cc high for 3 cycles at the first beat's due cycle -> first ack delayed by exactly 3 cycles; data order unchanged.
